// File: rtl/exalu_pkg.sv
// Shared types for the sequential extended ALU: operation codes and FSM states.
package exalu_pkg;

  typedef enum logic [2:0] {
    NOP     = 3'd0,
    EXTRACT = 3'd1,
    BYTEIN  = 3'd2,
    MULLO   = 3'd3,
    CLMUL   = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic isIterative(input logic [2:0] code);
    return (code == MULLO) || (code == CLMUL);
  endfunction

endpackage

// File: rtl/exalu_mulstep.sv
// One multiply step: folds a*b[MUL_STEP-1:0] into acc (add or GF(2) xor), then shifts a and b.
module exalu_mulstep #(
  parameter int DATA_W   = 256,
  parameter int MUL_STEP = 8
) (
  input  logic              clmul,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] accNext,
  output logic [DATA_W-1:0] aNext,
  output logic [DATA_W-1:0] bNext
);

  logic [DATA_W-1:0] prod;

  always_comb begin
    prod = '0;
    // Shift-and-combine over the low multiplier digit; identical structure for both modes.
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (b[i]) begin
        prod = clmul ? (prod ^ (a << i)) : (prod + (a << i));
      end
    end
    accNext = clmul ? (acc ^ prod) : (acc + prod);
    aNext   = a << MUL_STEP;
    bNext   = b >> MUL_STEP;
  end

endmodule

// File: rtl/exalu_seq.sv
// Sequential extended ALU: single-cycle EXTRACT/BYTEIN/NOP and iterative MULLO/CLMUL.
module exalu_seq
  import exalu_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 8
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N  = DATA_W / MUL_STEP;
  localparam int CW = $clog2(N) + 1;
  localparam logic [DATA_W-1:0] XMASK = {DATA_W{1'b1}} >> (DATA_W - XLEN);

  state_t            state;
  logic [CW-1:0]     iter;
  logic [DATA_W-1:0] acc, a, b;
  logic [DATA_W-1:0] accNext, aNext, bNext;
  logic              clmulMode;
  logic [DATA_W-1:0] quick;
  logic              illegal;

  exalu_mulstep #(
    .DATA_W  (DATA_W),
    .MUL_STEP(MUL_STEP)
  ) mulStep (
    .clmul  (clmulMode),
    .acc    (acc),
    .a      (a),
    .b      (b),
    .accNext(accNext),
    .aNext  (aNext),
    .bNext  (bNext)
  );

  always_comb begin
    quick   = '0;
    illegal = 1'b0;
    case (op)
      NOP:          quick = '0;
      EXTRACT:      quick = (d1 >> d2) & XMASK;
      BYTEIN:       quick = {d1[DATA_W-9:0], d2[7:0]};
      MULLO, CLMUL: quick = '0;
      default:      illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state     <= IDLE;
      result    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      iter      <= '0;
      acc       <= '0;
      a         <= '0;
      b         <= '0;
      clmulMode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a         <= d1;
            b         <= d2;
            acc       <= '0;
            iter      <= '0;
            clmulMode <= (op == CLMUL);
            err       <= illegal;
            busy      <= 1'b1;
            if (isIterative(op)) begin
              state  <= RUN;
              result <= '0;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              result <= quick;
            end
          end
        end
        RUN: begin
          acc <= accNext;
          a   <= aNext;
          b   <= bNext;
          // Final step's sum goes straight to result so DONE follows the Nth RUN cycle.
          if (iter == CW'(N - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= accNext;
          end else begin
            iter <= iter + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exalu_seq.sv
// Self-checking bench for exalu_seq: directed corner cases plus random ops vs an arithmetic model.
module tb_exalu_seq;

  localparam int DATA_W = 256;
  localparam int XLEN   = 32;
  localparam int MSTEP  = 8;
  localparam int ITER   = DATA_W / MSTEP;

  logic              clock = 1'b0;
  logic              resetN;
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] d1, d2;
  logic [DATA_W-1:0] result;
  logic              busy, done, err;

  int nTests = 0;
  int nFail  = 0;

  exalu_seq #(
    .DATA_W  (DATA_W),
    .XLEN    (XLEN),
    .MUL_STEP(MSTEP)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .start (start),
    .op    (op),
    .d1    (d1),
    .d2    (d2),
    .result(result),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd256();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: results straight from the arithmetic definitions.
  task automatic model(input logic [2:0] code, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                       output logic [DATA_W-1:0] res, output logic e, output int lat);
    logic [2*DATA_W-1:0] wide;
    res = '0; e = 1'b0; lat = 1;
    case (code)
      3'd0: res = '0;
      3'd1: res = (y >= DATA_W) ? '0 : ((x >> y) % (DATA_W'(1) << XLEN));
      3'd2: res = (x << 8) | DATA_W'(y % 256);
      3'd3: begin
        wide = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        res  = wide[DATA_W-1:0];
        lat  = ITER + 1;
      end
      3'd4: begin
        for (int i = 0; i < DATA_W; i++) if (y[i]) res = res ^ (x << i);
        lat = ITER + 1;
      end
      default: e = 1'b1;
    endcase
  endtask

  // Issue one op from IDLE and check latency, busy, result, err and post-done behaviour.
  task automatic runOp(input string tag, input logic [2:0] code, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] expRes;
    logic              expErr;
    int                expLat, k;
    model(code, x, y, expRes, expErr, expLat);
    op = code; d1 = x; d2 = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; d1 = rnd256(); d2 = rnd256();
    k = 1;
    while (!done && k < ITER + 10) begin
      if (!busy) begin
        check({tag, "_busyRun"}, DATA_W'(busy), DATA_W'(1));
        break;
      end
      @(posedge clock); #1;
      k++;
    end
    check({tag, "_lat"}, DATA_W'(k), DATA_W'(expLat));
    check({tag, "_res"}, result, expRes);
    check({tag, "_err"}, DATA_W'(err), DATA_W'(expErr));
    check({tag, "_busyDone"}, DATA_W'(busy), DATA_W'(1));
    @(posedge clock); #1;
    check({tag, "_doneFall"}, DATA_W'({busy, done}), DATA_W'(0));
    check({tag, "_hold"}, result, expRes);
  endtask

  initial begin
    logic [DATA_W-1:0] tmp;
    int                nDone;
    resetN = 1'b0; start = 1'b1; op = 3'd2; d1 = 256'h12; d2 = 256'h34;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs", {result[DATA_W-4:0], busy, done, err}, '0);
    resetN = 1'b1; start = 1'b0;
    @(posedge clock); #1;

    tmp = 256'hDEADBEEF << 64;
    runOp("extract64", 3'd1, tmp, 256'd64);
    check("extract64_val", result, 256'hDEADBEEF);
    runOp("extract300", 3'd1, tmp, 256'd300);
    runOp("mul3x5", 3'd3, 256'd3, 256'd5);
    check("mul3x5_val", result, 256'd15);
    tmp = 256'd1 << 255;
    runOp("mulOvf", 3'd3, tmp, 256'd2);
    check("mulOvf_val", result, '0);
    runOp("clmul3x3", 3'd4, 256'd3, 256'd3);
    check("clmul3x3_val", result, 256'd5);
    runOp("clmulTop", 3'd4, 256'h87, 256'd1 << 248);
    check("clmulTop_val", result, 256'h87 << 248);

    // Start while busy must not disturb the running MULLO.
    op = 3'd3; d1 = 256'd3; d2 = 256'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; nDone = 0;
    for (int i = 1; i <= ITER + 8; i++) begin
      if (i >= 5 && i <= 12) begin start = 1'b1; op = 3'd1; d1 = 256'hFFFF; d2 = 256'd0; end
      else start = 1'b0;
      if (done) begin
        nDone++;
        check("busyStart_res", result, 256'd15);
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    check("busyStart_dones", DATA_W'(nDone), DATA_W'(1));

    // Reset in the middle of a MULLO aborts it.
    op = 3'd3; d1 = 256'd3; d2 = 256'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    resetN = 1'b0;
    @(posedge clock); #1;
    check("midReset_outs", {result[DATA_W-4:0], busy, done, err}, '0);
    resetN = 1'b1; nDone = 0;
    repeat (ITER + 4) begin
      if (done) nDone++;
      @(posedge clock); #1;
    end
    check("midReset_noDone", DATA_W'(nDone), DATA_W'(0));
    runOp("bytein", 3'd2, 256'h12, 256'h34);
    check("bytein_val", result, 256'h1234);

    runOp("illegal7", 3'd7, rnd256(), rnd256());
    check("illegal7_err", DATA_W'(err), DATA_W'(1));
    runOp("nopAfterIll", 3'd0, rnd256(), rnd256());
    check("nop_errClr", DATA_W'(err), DATA_W'(0));

    for (int t = 0; t < 40; t++) begin
      logic [2:0] code;
      code = 3'($urandom_range(0, 7));
      tmp  = rnd256();
      if (code == 3'd1) runOp("rndExtract", code, rnd256(), DATA_W'($urandom_range(0, 300)));
      else if (code == 3'd2) runOp("rndByte", code, rnd256(), tmp);
      else runOp("rndOp", code, rnd256(), ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : tmp);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/exalu_seq.md
EXALU_SEQ -- requirements
Module: exalu_seq

Interface
REQ-001 Parameter DATA_W, default 256, shall set the operand and result width; it shall be a power of two.
REQ-002 Parameter XLEN, default 32, shall set the EXTRACT mask width; XLEN <= DATA_W.
REQ-003 Parameter MUL_STEP, default 8, shall set the multiplier bits consumed per cycle; DATA_W % MUL_STEP == 0.
REQ-004 clock  input  1  sole clock; all state shall update on its rising edge.
REQ-005 resetN  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 op  input  3  operation code, exalu_pkg::op_t.
REQ-008 d1  input  DATA_W  operand 1 (multiplicand / source).
REQ-009 d2  input  DATA_W  operand 2 (multiplier / shift amount / byte).
REQ-010 result  output  DATA_W  registered result, held until the next accepted start.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-013 err  output  1  set with done when op was illegal; held with result.

Function
REQ-014 The FSM shall have states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, d1, d2 and op shall be captured, and result and err shall be cleared.
REQ-016 Single-cycle ops shall transition IDLE->DONE; result shall be written on the accepting edge; done=1 in the next cycle.
REQ-017 Iterative ops shall transition IDLE->RUN, stay exactly N=DATA_W/MUL_STEP cycles, then go to DONE; done shall rise N+1 cycles after the accepting edge.
REQ-018 DONE shall last one cycle and then return to IDLE unconditionally.
REQ-019 start shall be ignored while busy=1; operands shall not be recaptured.
REQ-020 op 0 NOP: single-cycle; result=0.
REQ-021 op 1 EXTRACT: single-cycle; result=(d1 >> d2) & (2^XLEN-1), using the full-width d2; d2 >= DATA_W shall give 0.
REQ-022 op 2 BYTEIN: single-cycle; result={d1[DATA_W-9:0], d2[7:0]}.
REQ-023 op 3 MULLO: iterative; result=(d1*d2) mod 2^DATA_W, unsigned.
REQ-024 op 4 CLMUL: iterative; result=low DATA_W bits of the carry-less (GF(2)) product of d1 and d2.
REQ-025 Each RUN cycle shall work as follows: acc op= a*b[MUL_STEP-1:0] (add for MULLO, xor for CLMUL); then a<<=MUL_STEP and b>>=MUL_STEP; all values truncated to DATA_W.
REQ-026 op 5..7 shall be illegal: single-cycle; result=0; err=1.
REQ-027 Overflow beyond DATA_W shall be discarded silently; no flag.
REQ-028 Within one DONE cycle, done and busy shall both be 1; start in that cycle shall be ignored.

Reset
REQ-029 Reset shall force state=IDLE, result=0, done=0, err=0, busy=0 and clear the iteration counter, acc, a and b.
REQ-030 Reset during RUN or DONE shall abort the operation; no done pulse shall follow.
REQ-031 resetN=0 shall override start in the same cycle.

Structure
REQ-032 exalu_pkg shall hold op_t (NOP, EXTRACT, BYTEIN, MULLO, CLMUL) and state_t (IDLE, RUN, DONE).
REQ-033 One combinational sub-module, exalu_mulstep, shall compute one REQ-025 step, parametrised by DATA_W, MUL_STEP and a clmul mode input.
REQ-034 The iteration counter width shall be $clog2(N)+1.

Verification (DATA_W=256, XLEN=32, MUL_STEP=8)
REQ-035 EXTRACT test: d1=0xDEADBEEF<<64, d2=64 -> done at +1, result=0xDEADBEEF; d2=300 -> result=0.
REQ-036 MULLO test: d1=3, d2=5 -> busy at +1..+33, done at +33, result=15; d1=2^255, d2=2 -> result=0.
REQ-037 CLMUL test: d1=3, d2=3 -> result=5 at +33; d1=0x87, d2=1<<248 -> result=0x87<<248.
REQ-038 Start-while-busy test: MULLO 3*5 accepted; in RUN, assert start with op=1 and different operands -> single done, result=15.
REQ-039 Reset-mid-operation test: resetN=0 at +10 of a MULLO -> all outputs 0 the next cycle, no done; a subsequent BYTEIN d1=0x12, d2=0x34 -> result=0x1234.
REQ-040 Illegal-op test: op=7 -> done at +1, err=1, result=0; a following NOP clears err.
